// File: rtl/sccb_slave_regfile.sv
// SCCB responder emulating the OV7725 register bank (256 x 8).
// Ports: sys_clk/sys_rst_n; scl, sda_in bus inputs; sda_oe open-drain pull;
//   reg_wr_en/addr/data write strobe; dbg_rd_addr/data backdoor; busy.
module sccb_slave_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h21,
  parameter logic [7:0] PID_VAL  = 8'h77,
  parameter logic [7:0] VER_VAL  = 8'h21
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  input  logic [7:0] dbg_rd_addr,
  output logic [7:0] dbg_rd_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, DEV, ACK, SUB, WDAT, RDAT, RACK, WAIT_STOP
  } state_t;

  localparam logic [7:0] PID_ADR = 8'h0A;
  localparam logic [7:0] VER_ADR = 8'h0B;
  localparam logic [7:0] COM_ADR = 8'h12;

  // [0],[1] synchronizer, [2] history
  logic [2:0] scl_q, sda_q;
  logic       scl_s, scl_h, sda_s, sda_h;
  logic       rise_c, fall_c, start_c, stop_c;

  state_t     state_q, state_d;
  state_t     ack_nxt_q, ack_nxt_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] sh_q, sh_d;
  logic [6:0] rd_sh_q, rd_sh_d;
  logic [7:0] sub_q, sub_d;
  logic       ack_drv_q, ack_drv_d;
  logic       done_q, done_d;
  logic       ld_q, ld_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] mem_q [256];
  logic [7:0] byte_w, sub_rd;
  logic       byte_end;

  assign scl_s = scl_q[1];
  assign scl_h = scl_q[2];
  assign sda_s = sda_q[1];
  assign sda_h = sda_q[2];

  assign rise_c  = scl_s & ~scl_h;
  assign fall_c  = ~scl_s & scl_h;
  assign start_c = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_c  = scl_s & scl_h & ~sda_h & sda_s;

  assign byte_w   = {sh_q, sda_s};
  assign byte_end = rise_c && (cnt_q == 3'd7);

  assign sda_oe      = oe_q;
  assign busy        = busy_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;

  always_comb begin
    unique case (1'b1)
      (sub_q == PID_ADR): sub_rd = PID_VAL;
      (sub_q == VER_ADR): sub_rd = VER_VAL;
      default:            sub_rd = mem_q[sub_q];
    endcase
  end

  always_comb begin
    unique case (1'b1)
      (dbg_rd_addr == PID_ADR): dbg_rd_data = PID_VAL;
      (dbg_rd_addr == VER_ADR): dbg_rd_data = VER_VAL;
      default:                  dbg_rd_data = mem_q[dbg_rd_addr];
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end

  always_comb begin
    state_d   = state_q;
    ack_nxt_d = ack_nxt_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    rd_sh_d   = rd_sh_q;
    sub_d     = sub_q;
    ack_drv_d = ack_drv_q;
    done_d    = done_q;
    ld_d      = ld_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (start_c) begin
      state_d   = DEV;
      cnt_d     = 3'd0;
      oe_d      = 1'b0;
      busy_d    = 1'b1;
      ack_drv_d = 1'b0;
      done_d    = 1'b0;
      ld_d      = 1'b0;
    end else if (stop_c) begin
      state_d   = IDLE;
      cnt_d     = 3'd0;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
      ack_drv_d = 1'b0;
      done_d    = 1'b0;
      ld_d      = 1'b0;
    end else begin
      unique case (state_q)
        DEV: begin
          if (rise_c) begin
            sh_d  = byte_w[6:0];
            cnt_d = cnt_q + 3'd1;
          end
          if (byte_end) begin
            if (byte_w[7:1] == DEV_ADDR) begin
              state_d   = ACK;
              ack_nxt_d = byte_w[0] ? RDAT : SUB;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        SUB: begin
          if (rise_c) begin
            sh_d  = byte_w[6:0];
            cnt_d = cnt_q + 3'd1;
          end
          if (byte_end) begin
            sub_d     = byte_w;
            state_d   = ACK;
            ack_nxt_d = WDAT;
          end
        end
        WDAT: begin
          if (rise_c) begin
            sh_d  = byte_w[6:0];
            cnt_d = cnt_q + 3'd1;
          end
          if (byte_end) begin
            wr_en_d   = 1'b1;
            wr_addr_d = sub_q;
            wr_data_d = byte_w;
            sub_d     = sub_q + 8'd1;
            state_d   = ACK;
            ack_nxt_d = WDAT;
          end
        end
        ACK: begin
          // first fall starts the pull, second fall ends it
          if (fall_c) begin
            if (!ack_drv_q) begin
              ack_drv_d = 1'b1;
              oe_d      = 1'b1;
            end else begin
              ack_drv_d = 1'b0;
              state_d   = ack_nxt_q;
              if (ack_nxt_q == RDAT) begin
                rd_sh_d = sub_rd[6:0];
                oe_d    = ~sub_rd[7];
              end else begin
                oe_d = 1'b0;
              end
            end
          end
        end
        RDAT: begin
          if (rise_c) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) done_d = 1'b1;
          end
          if (fall_c) begin
            if (done_q) begin
              done_d  = 1'b0;
              oe_d    = 1'b0;
              state_d = RACK;
            end else if (ld_q) begin
              // re-entry after master ACK: load at this fall
              ld_d    = 1'b0;
              rd_sh_d = sub_rd[6:0];
              oe_d    = ~sub_rd[7];
            end else begin
              rd_sh_d = {rd_sh_q[5:0], 1'b0};
              oe_d    = ~rd_sh_q[6];
            end
          end
        end
        RACK: begin
          if (rise_c) begin
            if (!sda_s) begin
              sub_d   = sub_q + 8'd1;
              ld_d    = 1'b1;
              state_d = RDAT;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        IDLE, WAIT_STOP: begin
          state_d = state_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      ack_nxt_q <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      rd_sh_q   <= '0;
      sub_q     <= '0;
      ack_drv_q <= 1'b0;
      done_q    <= 1'b0;
      ld_q      <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ack_nxt_q <= ack_nxt_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      rd_sh_q   <= rd_sh_d;
      sub_q     <= sub_d;
      ack_drv_q <= ack_drv_d;
      done_q    <= done_d;
      ld_q      <= ld_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // ID registers are read-only; COM7 bit7 wipes the bank
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 256; i++) mem_q[i] <= 8'h00;
    end else if (wr_en_d) begin
      if (wr_addr_d == COM_ADR && wr_data_d[7]) begin
        for (int i = 0; i < 256; i++)
          mem_q[i] <= (i == 18) ? {1'b0, wr_data_d[6:0]} : 8'h00;
      end else if (wr_addr_d != PID_ADR && wr_addr_d != VER_ADR) begin
        mem_q[wr_addr_d] <= wr_data_d;
      end
    end
  end

endmodule

// File: tb/tb_sccb_slave_regfile.sv
// Directed bench for sccb_slave_regfile with write-strobe scoreboard.
// Ports: drives scl/sda as bus master, checks sda_oe, strobes, backdoor.
module tb_sccb_slave_regfile;

  localparam time Q = 80ns;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic       reg_wr_en;
  logic [7:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic [7:0] dbg_rd_addr = 8'h00;
  logic [7:0] dbg_rd_data;
  logic       busy;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  logic oe_seen = 1'b0;

  assign sda_line = sda_m & ~sda_oe;

  always #5 sys_clk = ~sys_clk;

  sccb_slave_regfile dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .scl        (scl_m),
    .sda_in     (sda_line),
    .sda_oe     (sda_oe),
    .reg_wr_en  (reg_wr_en),
    .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data),
    .dbg_rd_addr(dbg_rd_addr),
    .dbg_rd_data(dbg_rd_data),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (sda_oe === 1'b1) oe_seen = 1'b1;
    if (sys_rst_n && reg_wr_en === 1'b1) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL wr_unexp: got %h/%h exp none",
               reg_wr_addr, reg_wr_data);
      end
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", reg_wr_addr, e.a);
        chk("wr_data", reg_wr_data, e.d);
      end
    end
  end

  task automatic bus_start();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #(2*Q);
  endtask

  task automatic send_bit(input logic b, output logic rb);
    sda_m = b; #Q;
    scl_m = 1'b1; #Q;
    rb = sda_line; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic x;
    for (int i = 7; i >= 0; i--) send_bit(b[i], x);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic x;
    for (int i = 7; i >= 0; i--) send_bit(1'b1, d[i]);
    send_bit(nack, x);
  endtask

  task automatic peek(input logic [7:0] a, input logic [7:0] exp,
                      input string tag);
    dbg_rd_addr = a; #1;
    chk(tag, dbg_rd_data, exp);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic       x;
    logic [7:0] rd;

    #100;
    chk("rst_oe", {7'd0, sda_oe}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_wr_en", {7'd0, reg_wr_en}, 8'h00);
    chk("rst_wr_addr", reg_wr_addr, 8'h00);
    chk("rst_wr_data", reg_wr_data, 8'h00);
    sys_rst_n = 1'b1;
    #100;
    peek(8'h0A, 8'h77, "pid");
    peek(8'h17, 8'h00, "rst_mem17");

    // plain 3-phase write
    bus_start();
    #1 chk("busy_on", {7'd0, busy}, 8'h01);
    send_byte(8'h42, ack); chk("w1_ack_id", {7'd0, ack}, 8'h00);
    send_byte(8'h17, ack); chk("w1_ack_sub", {7'd0, ack}, 8'h00);
    exp_q.push_back('{a: 8'h17, d: 8'h23});
    send_byte(8'h23, ack); chk("w1_ack_dat", {7'd0, ack}, 8'h00);
    bus_stop();
    chk("busy_off", {7'd0, busy}, 8'h00);
    peek(8'h17, 8'h23, "w1_mem");

    // address write, then separate 1-byte read with NACK
    bus_start();
    send_byte(8'h42, ack); chk("r1_ack_id", {7'd0, ack}, 8'h00);
    send_byte(8'h0A, ack); chk("r1_ack_sub", {7'd0, ack}, 8'h00);
    bus_stop();
    bus_start();
    send_byte(8'h43, ack); chk("r1_ack_rd", {7'd0, ack}, 8'h00);
    read_byte(1'b1, rd);   chk("r1_data", rd, 8'h77);
    bus_stop();

    // 2-byte read with master ACK between
    bus_start();
    send_byte(8'h42, ack);
    send_byte(8'h0A, ack);
    bus_start();
    send_byte(8'h43, ack); chk("r2_ack_rd", {7'd0, ack}, 8'h00);
    read_byte(1'b0, rd);   chk("r2_data0", rd, 8'h77);
    read_byte(1'b1, rd);   chk("r2_data1", rd, 8'h21);
    bus_stop();

    // wrong device ID
    oe_seen = 1'b0;
    bus_start();
    send_byte(8'h40, ack); chk("bad_ack_id", {7'd0, ack}, 8'h01);
    send_byte(8'h12, ack); chk("bad_ack_sub", {7'd0, ack}, 8'h01);
    send_byte(8'h55, ack); chk("bad_ack_dat", {7'd0, ack}, 8'h01);
    bus_stop();
    chk("bad_oe", {7'd0, oe_seen}, 8'h00);
    peek(8'h12, 8'h00, "bad_mem12");
    peek(8'h17, 8'h23, "bad_mem17");

    // read-only register write
    bus_start();
    send_byte(8'h42, ack);
    send_byte(8'h0B, ack);
    exp_q.push_back('{a: 8'h0B, d: 8'h55});
    send_byte(8'h55, ack); chk("ro_ack", {7'd0, ack}, 8'h00);
    bus_stop();
    peek(8'h0B, 8'h21, "ro_ver");

    // sub-address wrap
    bus_start();
    send_byte(8'h42, ack);
    send_byte(8'hFF, ack);
    exp_q.push_back('{a: 8'hFF, d: 8'hAA});
    send_byte(8'hAA, ack);
    exp_q.push_back('{a: 8'h00, d: 8'hBB});
    send_byte(8'hBB, ack); chk("wrap_ack", {7'd0, ack}, 8'h00);
    bus_stop();
    peek(8'hFF, 8'hAA, "wrap_ff");
    peek(8'h00, 8'hBB, "wrap_00");

    // soft reset through register 12
    bus_start();
    send_byte(8'h42, ack);
    send_byte(8'h12, ack);
    exp_q.push_back('{a: 8'h12, d: 8'h86});
    send_byte(8'h86, ack);
    bus_stop();
    peek(8'h17, 8'h00, "srst_17");
    peek(8'h12, 8'h06, "srst_12");
    peek(8'hFF, 8'h00, "srst_ff");

    // hard reset in the middle of the sub-address byte
    bus_start();
    send_byte(8'h42, ack);
    send_bit(1'b0, x);
    send_bit(1'b0, x);
    send_bit(1'b0, x);
    send_bit(1'b1, x);
    chk("mid_busy", {7'd0, busy}, 8'h01);
    sys_rst_n = 1'b0;
    #20;
    chk("mr_oe", {7'd0, sda_oe}, 8'h00);
    chk("mr_busy", {7'd0, busy}, 8'h00);
    chk("mr_wr_en", {7'd0, reg_wr_en}, 8'h00);
    chk("mr_wr_addr", reg_wr_addr, 8'h00);
    chk("mr_wr_data", reg_wr_data, 8'h00);
    sys_rst_n = 1'b1;
    #100;
    bus_start();
    send_byte(8'h42, ack); chk("mr_ack_id", {7'd0, ack}, 8'h00);
    send_byte(8'h18, ack);
    exp_q.push_back('{a: 8'h18, d: 8'hA0});
    send_byte(8'hA0, ack); chk("mr_ack_dat", {7'd0, ack}, 8'h00);
    bus_stop();
    peek(8'h18, 8'hA0, "mr_mem18");
    peek(8'h12, 8'h00, "mr_mem12");

    #200;
    chk("sb_empty", 8'(exp_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
